// File: rtl/mem_io_responder_pkg.sv
// Shared decode constants and helpers for the CPU memory-bus responder.
// Address bits [17:16] select RAM, unmapped space or the IO page.
package mem_io_responder_pkg;

    localparam int unsigned RAM_ADDR_W_DEF = 17;
    localparam int unsigned RAM_BYTES      = 1 << RAM_ADDR_W_DEF;

    localparam logic [1:0] IO_SEL      = 2'b11;
    localparam logic [2:0] IO_UART_OFF = 3'd0;
    localparam logic [2:0] IO_CLK_OFF  = 3'd4;
    localparam logic [7:0] STOP_BYTE   = 8'h00;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_UNMAPPED,
        REGION_IO
    } region_e;

    function automatic region_e decode_region(input logic [1:0] hi);
        if (hi == IO_SEL) begin
            return REGION_IO;
        end else if (hi[1]) begin
            return REGION_UNMAPPED;
        end
        return REGION_RAM;
    endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte FIFO for the UART TX path; a push into a full FIFO is accepted only
// when a pop happens in the same cycle. near_full_o is registered.
module byte_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned MARGIN = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [7:0]               data_i,
    input  logic                     pop_i,
    output logic [7:0]               data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     near_full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] ONE       = (PW + 1)'(1);
    localparam logic [PW:0] DEPTH_C   = (PW + 1)'(DEPTH);
    localparam logic [PW:0] NEAR_FULL = (PW + 1)'(DEPTH - MARGIN);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          near_full_q;
    logic          push_ok, pop_ok;

    assign pop_ok  = pop_i && (cnt_q != '0);
    assign push_ok = push_i && ((cnt_q < DEPTH_C) || pop_ok);

    always_comb begin
        wr_d  = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d  = pop_ok ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + ONE;
            2'b01:   cnt_d = cnt_q - ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            near_full_q <= 1'b0;
        end else begin
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            near_full_q <= (cnt_d >= NEAR_FULL);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_q] <= data_i;
        end
    end

    assign data_o      = mem_q[rd_q];
    assign empty_o     = (cnt_q == '0);
    assign full_o      = (cnt_q == DEPTH_C);
    assign near_full_o = near_full_q;
    assign count_o     = cnt_q;

endmodule

// File: rtl/mem_io_responder.sv
// CPU byte-bus responder: main RAM, UART byte channel, cycle counter with
// snapshot for coherent multibyte reads, and the sticky program-stop write.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int unsigned RAM_ADDR_W  = RAM_ADDR_W_DEF,
    parameter int unsigned TX_DEPTH    = 8,
    parameter int unsigned FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        cpu_en,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        program_stop,
    output logic        tx_overflow
);

    logic [7:0]  ram_q [2**RAM_ADDR_W];
    logic [7:0]  rdata_q, rdata_d;
    logic [31:0] cnt_q, snap_q, snap_d;
    logic        rx_pop_q, rx_pop_d;
    logic        stop_q, stop_d;
    logic        ovf_q, ovf_d;
    logic        ram_we, push;
    logic [7:0]  push_data;
    logic        fifo_empty, fifo_full, tx_pop;
    logic [$clog2(TX_DEPTH):0] unused_fifo_count;
    logic [13:0] unused_addr_hi;

    region_e                 region;
    logic [2:0]              io_off;
    logic [RAM_ADDR_W-1:0]   ram_addr;

    assign region         = decode_region(cpu_a[17:16]);
    assign io_off         = cpu_a[2:0];
    assign ram_addr       = cpu_a[RAM_ADDR_W-1:0];
    assign unused_addr_hi = cpu_a[31:18];
    assign tx_pop         = !fifo_empty && tx_ready;

    always_comb begin
        rdata_d   = rdata_q;
        snap_d    = snap_q;
        rx_pop_d  = 1'b0;
        stop_d    = stop_q;
        ram_we    = 1'b0;
        push      = 1'b0;
        push_data = cpu_wdata;
        if (cpu_en) begin
            unique case (region)
                REGION_RAM: begin
                    if (cpu_wr) ram_we = 1'b1;
                    else        rdata_d = ram_q[ram_addr];
                end
                REGION_UNMAPPED: begin
                    if (!cpu_wr) rdata_d = '0;
                end
                default: begin
                    if (cpu_wr) begin
                        if (!stop_q && io_off == IO_UART_OFF && cpu_wdata != STOP_BYTE) begin
                            push = 1'b1;
                        end else if (!stop_q && io_off == IO_CLK_OFF) begin
                            // stop marker goes through the FIFO even though it is the filtered byte
                            push      = 1'b1;
                            push_data = STOP_BYTE;
                            stop_d    = 1'b1;
                        end
                    end else begin
                        rdata_d = '0;
                        case (io_off)
                            IO_UART_OFF: begin
                                if (rx_valid) begin
                                    rdata_d  = rx_data;
                                    rx_pop_d = 1'b1;
                                end
                            end
                            IO_CLK_OFF: begin
                                rdata_d = cnt_q[7:0];
                                snap_d  = cnt_q;
                            end
                            3'd5:    rdata_d = snap_q[15:8];
                            3'd6:    rdata_d = snap_q[23:16];
                            3'd7:    rdata_d = snap_q[31:24];
                            default: rdata_d = '0;
                        endcase
                    end
                end
            endcase
        end
        ovf_d = ovf_q | (push && fifo_full && !tx_pop);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rdata_q  <= '0;
            snap_q   <= '0;
            cnt_q    <= '0;
            rx_pop_q <= 1'b0;
            stop_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            snap_q   <= snap_d;
            cnt_q    <= cnt_q + 32'd1;
            rx_pop_q <= rx_pop_d;
            stop_q   <= stop_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram_q[ram_addr] <= cpu_wdata;
        end
    end

    byte_fifo #(
        .DEPTH  (TX_DEPTH),
        .MARGIN (FULL_MARGIN)
    ) u_tx_fifo (
        .clk_i       (clk_in),
        .rst_ni      (rst_in),
        .push_i      (push),
        .data_i      (push_data),
        .pop_i       (tx_ready),
        .data_o      (tx_data),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .near_full_o (io_buffer_full),
        .count_o     (unused_fifo_count)
    );

    assign cpu_rdata    = rdata_q;
    assign tx_valid     = !fifo_empty;
    assign rx_pop       = rx_pop_q;
    assign program_stop = stop_q;
    assign tx_overflow  = ovf_q;

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Responder end of the CPU's byte-wide memory bus (address / write / data-out in, data-in back).
- Implements the 128KB main RAM with 1-cycle read latency, the UART byte channel at 0x30000, the cycle counter at 0x30004 and the program-stop write.
- Sits beside the CPU top, between the CPU memory port and the UART TX/RX logic.
- Drives io_buffer_full back to the CPU.

Parameters:
- RAM_ADDR_W, 17, RAM address width (2^17 bytes).
- TX_DEPTH, 8, TX FIFO depth in bytes; power of two, >= 4.
- FULL_MARGIN, 2, free slots still remaining when io_buffer_full asserts.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous reset, active-low.
- cpu_en  in  1  bus carries an access this cycle; 0 = idle, no side effects.
- cpu_a  in  32  byte address; only [17:0] decoded.
- cpu_wr  in  1  1 = write, 0 = read.
- cpu_wdata  in  8  write byte.
- cpu_rdata  out  8  read byte, valid the cycle after the read.
- io_buffer_full  out  1  TX FIFO near full.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  UART accepts head this cycle.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data holds an unread byte.
- rx_pop  out  1  1-cycle pulse consuming rx_data.
- program_stop  out  1  sticky, set by the stop write.
- tx_overflow  out  1  sticky, set when a TX byte is dropped.

Behaviour:
- Reset (rst_in==0 at a clk_in edge) clears cpu_rdata, rx_pop, program_stop, tx_overflow, the FIFO pointers/count, the cycle counter and the snapshot register to 0. RAM contents are not cleared.
- All state updates only on clk_in rising edges.
- Decode:
  - RAM when a[17:16]!=2'b11 and a[17]==0.
  - a[17:16]==2'b10: unmapped; reads return 0, writes ignored.
  - IO when a[17:16]==2'b11, using a[2:0].
- RAM read: cpu_rdata <= ram[a[16:0]] at the edge after the request. Back-to-back reads are pipelined at 1 byte/cycle.
- RAM write: stored at the edge. A read of the same address in the next cycle returns the new byte.
- Cycle counter: 32-bit, +1 every cycle out of reset, wraps at 2^32-1 -> 0.
- Read 0x30004: cpu_rdata <= counter[7:0]; snapshot <= counter.
- Read 0x30005/6/7: return snapshot[15:8] / [23:16] / [31:24] for consistent multibyte reads.
- Read 0x30000:
  - If rx_valid: cpu_rdata <= rx_data and rx_pop=1 for exactly one cycle, asserted registered on the following cycle.
  - Else: cpu_rdata <= 0, no pop.
- Other IO offsets: reads return 0, writes ignored.
- Write 0x30000:
  - Data 0x00 is ignored.
  - Otherwise push into the TX FIFO.
- Write 0x30004:
  - Push 0x00 into the FIFO; this bypasses the zero filter.
  - Set program_stop.
  - Once program_stop=1, all further IO writes are ignored. RAM writes and all reads continue.
- Reads with cpu_en=0: cpu_rdata holds its value; no pop and no snapshot update.
- TX FIFO:
  - Pop when tx_valid && tx_ready.
  - A push is accepted if count<TX_DEPTH, or if a pop occurs in the same cycle.
  - Simultaneous push+pop keeps count unchanged.
  - A push to a full FIFO without a pop is dropped and sets tx_overflow.
  - Pointers wrap modulo TX_DEPTH.
- io_buffer_full = (count >= TX_DEPTH-FULL_MARGIN), registered from the next-cycle count.

Decomposition:
- Shared package holds:
  - IO_SEL (2'b11 on a[17:16]);
  - IO_UART_OFF=3'd0, IO_CLK_OFF=3'd4;
  - STOP_BYTE=8'h00;
  - RAM size constant.
- One sub-module: byte_fifo (parameterised DEPTH; push/pop/full/empty/count).
- RAM array, decode, counter and snapshot stay in the top.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 next cycle -> cpu_rdata==0xA5 one cycle after the read; reads of 0x1FFFF/0x00000 interleaved at 1/cycle return their stored bytes in order.
- 20 cycles after reset, read 0x30004..0x30007 on consecutive cycles -> bytes equal the counter value at the 0x30004 read (0x14 plus latency offset, upper bytes 0), not later values.
- rx_valid=1, rx_data=0x41, read 0x30000 -> cpu_rdata==0x41, rx_pop high exactly 1 cycle; repeat with rx_valid=0 -> cpu_rdata==0, rx_pop stays 0.
- tx_ready=0, write 0x31..0x38 to 0x30000 -> io_buffer_full rises after the 6th byte; the 9th write sets tx_overflow; writing 0x00 leaves count unchanged; raising tx_ready drains 0x31..0x38 in order.
- Write to 0x30004 -> 0x00 appears on tx_data after queued bytes, program_stop=1; a later write of 0x42 to 0x30000 is not queued.
- Assert rst_in=0 mid-drain with FIFO count 5 -> next cycle tx_valid=0, io_buffer_full=0, program_stop=0, counter restarts from 0; RAM byte at 0x00010 still 0xA5.
